serial_sub_sched: RTL

Sequencer and two-port arbiter for one shared 1-bit full-subtractor cell (d = a^b^bin, bout = ~a&b | ~a&bin | b&bin). The block accepts WIDTH-bit subtract requests from two requesters and grants them round-robin. It runs the granted operation bit-serially, LSB first, through the single cell, and returns difference, final borrow and zero flag with a one-cycle done pulse. It sits between the two client blocks and the shared subtractor datapath, replacing a WIDTH-bit ripple subtractor where area matters more than latency.

---
 rtl/serial_sub_sched.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/serial_sub_sched.sv
// Round-robin sequencer for two requesters sharing one 1-bit full-subtractor cell.
// Each granted request is subtracted bit-serially, LSB first, over WIDTH cycles.
module serial_sub_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic             ptr_reg, ptr_next;
  logic             id_reg, id_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-2:0] res_reg, res_next;
  logic             borrow_reg, borrow_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             gnt0_reg, gnt0_next;
  logic             gnt1_reg, gnt1_next;
  logic [WIDTH-1:0] diff_reg, diff_next;
  logic             bout_reg, bout_next;
  logic             zero_reg, zero_next;
  logic             done_id_reg, done_id_next;

  logic             cell_d, cell_bout;
  logic [WIDTH-1:0] a_shift, b_shift, res_shift;
  logic             sel;

  // The shared subtractor cell.
  assign cell_d    = a_reg[0] ^ b_reg[0] ^ borrow_reg;
  assign cell_bout = (~a_reg[0] & b_reg[0]) | (~a_reg[0] & borrow_reg) | (b_reg[0] & borrow_reg);

  // res_reg holds the WIDTH-1 bits already produced; the new bit enters at the top.
  assign res_shift = {cell_d, res_reg};

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign a_shift[gi] = a_reg[gi+1];
      assign b_shift[gi] = b_reg[gi+1];
    end
  endgenerate
  assign a_shift[WIDTH-1] = 1'b0;
  assign b_shift[WIDTH-1] = 1'b0;

  // On a tie the requester not served last wins.
  assign sel = (req0 && req1) ? ~ptr_reg : req1;

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    id_next      = id_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    res_next     = res_reg;
    borrow_next  = borrow_reg;
    cnt_next     = cnt_reg;
    gnt0_next    = 1'b0;
    gnt1_next    = 1'b0;
    diff_next    = diff_reg;
    bout_next    = bout_reg;
    zero_next    = zero_reg;
    done_id_next = done_id_reg;
    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          state_next  = SHIFT;
          a_next      = sel ? a1 : a0;
          b_next      = sel ? b1 : b0;
          borrow_next = 1'b0;
          cnt_next    = '0;
          id_next     = sel;
          gnt0_next   = ~sel;
          gnt1_next   = sel;
        end
      end
      SHIFT: begin
        borrow_next = cell_bout;
        res_next    = res_shift[WIDTH-1:1];
        a_next      = a_shift;
        b_next      = b_shift;
        cnt_next    = cnt_reg + CW'(1);
        if (cnt_reg == LAST) begin
          state_next   = DONE;
          diff_next    = res_shift;
          bout_next    = cell_bout;
          zero_next    = (res_shift == '0);
          done_id_next = id_reg;
          ptr_next     = id_reg;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= 1'b1;
      id_reg      <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      res_reg     <= '0;
      borrow_reg  <= 1'b0;
      cnt_reg     <= '0;
      gnt0_reg    <= 1'b0;
      gnt1_reg    <= 1'b0;
      diff_reg    <= '0;
      bout_reg    <= 1'b0;
      zero_reg    <= 1'b0;
      done_id_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      id_reg      <= id_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      res_reg     <= res_next;
      borrow_reg  <= borrow_next;
      cnt_reg     <= cnt_next;
      gnt0_reg    <= gnt0_next;
      gnt1_reg    <= gnt1_next;
      diff_reg    <= diff_next;
      bout_reg    <= bout_next;
      zero_reg    <= zero_next;
      done_id_reg <= done_id_next;
    end
  end

  assign gnt0    = gnt0_reg;
  assign gnt1    = gnt1_reg;
  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);
  assign done_id = done_id_reg;
  assign diff    = diff_reg;
  assign bout    = bout_reg;
  assign zero    = zero_reg;

endmodule
